// File: rtl/gray_counter_if.sv
// Counter control/status bundle for gray_counter: the master drives the
// controls, the slave (the counter) returns the binary and Gray count.
interface gray_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_bin,
    input  bin, gray, wrap
  );

  modport slave (
    input  en, up_dn, load, load_bin,
    output bin, gray, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code copy and a wrap pulse.
// All outputs come straight from flops; Gray is derived from the next binary value.
module gray_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic          clk,
  input  logic          rst,
  gray_counter_if.slave cnt
);
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;

  // Load beats counting; wrap only on a counted rollover, never on a load.
  always_comb begin
    bin_next  = cnt.bin;
    wrap_next = 1'b0;
    if (cnt.load) begin
      bin_next = cnt.load_bin;
    end else if (cnt.en) begin
      if (cnt.up_dn) begin
        bin_next  = cnt.bin + ONE;
        wrap_next = &cnt.bin;
      end else begin
        bin_next  = cnt.bin - ONE;
        wrap_next = ~|cnt.bin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt.bin  <= RST_BIN;
      cnt.gray <= RST_GRAY;
      cnt.wrap <= 1'b0;
    end else begin
      cnt.bin  <= bin_next;
      cnt.gray <= bin_next ^ (bin_next >> 1);
      cnt.wrap <= wrap_next;
    end
  end
endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous up/down counter that produces a registered, glitch-free Gray-code output plus its binary equivalent.
- Performs binary-to-Gray conversion; it is the encoding end of the Gray-to-binary decoders already in the code-converter library.
- Intended use: async-FIFO read/write pointers and other multi-bit values that cross clock domains, where only one bit may change per step.
- Gray is computed from the next binary value and registered, so no combinational logic drives the `gray` pin.

Parameters:
- `WIDTH`, 4: counter and code width in bits (minimum 2).
- `RST_VAL`, 0: binary reset value; its Gray equivalent is loaded into `gray` at reset.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous active-high reset.
- `en`, input, 1: count enable; one step per clock while high.
- `up_dn`, input, 1: 1 = increment, 0 = decrement; sampled only when `en` = 1.
- `load`, input, 1: synchronous load of `load_bin`.
- `load_bin`, input, `WIDTH`: binary value to load.
- `bin`, output, `WIDTH`: registered binary count.
- `gray`, output, `WIDTH`: registered Gray code of `bin`, always equal to `bin ^ (bin >> 1)`.
- `wrap`, output, 1: one-cycle registered pulse on a terminal-count rollover.

Behaviour:
- **Reset:** `rst` high at any time (async, mid-count included) forces `bin` = `RST_VAL`, `gray` = `RST_VAL ^ (RST_VAL >> 1)`, `wrap` = 0. Outputs hold these values until the first rising edge after `rst` deasserts.
- **Next-state priority, per rising edge:**
  1. `load` = 1: `bin_next` = `load_bin`; `en` and `up_dn` are ignored; `wrap_next` = 0.
  2. `en` = 1, `up_dn` = 1: `bin_next` = `bin + 1`, modulo 2^`WIDTH`.
  3. `en` = 1, `up_dn` = 0: `bin_next` = `bin - 1`, modulo 2^`WIDTH`.
  4. Otherwise: hold; `wrap_next` = 0.
- **Register update:** `bin` <= `bin_next`; `gray` <= `bin_next ^ (bin_next >> 1)`. Both registers update on the same edge, so latency is one clock from the enabling edge and `gray`/`bin` are never out of step.
- **Wrap:** `wrap_next` = 1 only when counting up from all-ones to 0, or counting down from 0 to all-ones. `wrap` is high for exactly the cycle in which `bin` shows the wrapped value.
- **Sustained counting:** continuous `en` with fixed direction produces exactly one `gray` bit change per clock, including across the wrap (e.g. `WIDTH` = 4: 1000 -> 0000).
- **Direction change:** changing `up_dn` mid-stream takes effect on the next enabled edge, with no extra or skipped step. The `gray` single-bit-change property still holds.
- **Load:** a load may change any number of bits; this is the only permitted multi-bit `gray` transition. A load landing on the terminal value does not assert `wrap`.
- **Idle:** with `en` = 0 and `load` = 0, the outputs are stable indefinitely.
- **Implementation constraint:** no latches; all outputs come directly from flops.

Test Plan:
- **Reset and count-up sweep:** assert `rst` mid-cycle, release, then `en` = 1, `up_dn` = 1 for 17 clocks (`WIDTH` = 4, `RST_VAL` = 0).
  - `gray` starts at 0000 and follows 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - `wrap` = 1 only on the cycle `gray` returns to 0000.
  - Every step changes exactly one `gray` bit, and `gray` == `bin ^ (bin >> 1)` every cycle.
- **Count down from reset:** `en` = 1, `up_dn` = 0 from `bin` = 0000.
  - Next cycle: `bin` = 1111, `gray` = 1000, `wrap` = 1.
  - Following cycle: `bin` = 1110, `gray` = 1001, `wrap` = 0.
- **Load priority:** `load` = 1, `load_bin` = 1011, `en` = 1, `up_dn` = 1 in the same cycle.
  - Next cycle: `bin` = 1011, `gray` = 1110, `wrap` = 0.
  - With `load` dropped and `en` held: `bin` = 1100, `gray` = 1010.
- **Direction reversal:** from `bin` = 0101, up one step then down one step, `en` held.
  - `bin` goes 0110 then 0101; `gray` goes 0101 then 0111.
  - Each transition is a single-bit change.
- **Hold and async reset mid-count:** `en` = 0 for 5 clocks at `bin` = 0111.
  - `bin` and `gray` (0100) stay constant.
  - Then assert `rst` between clock edges: `bin` = 0000 and `gray` = 0000 immediately, without waiting for `clk`.
- **Randomised check:** 1000 cycles of random `en`/`up_dn`/`load`/`load_bin`, compared against a reference model.
  - `bin` matches the model every cycle.
  - `gray` == `bin ^ (bin >> 1)` every cycle.
  - Any `gray` transition not caused by a load changes exactly one bit.
